// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder_nand cell processes one operand bit pair per clock, LSB first,
// with the carry held in a flip-flop. start/busy/done handshake around a three-state FSM.

module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    logic n1, n2, n3, x1, n4, n5, n6;

    // Classic nine-NAND full adder: first four gates form a XOR b, next four XOR in the carry.
    assign n1        = ~(a & b);
    assign n2        = ~(a & n1);
    assign n3        = ~(b & n1);
    assign x1        = ~(n2 & n3);
    assign n4        = ~(x1 & carry_in);
    assign n5        = ~(x1 & n4);
    assign n6        = ~(carry_in & n4);
    assign sum       = ~(n5 & n6);
    assign carry_out = ~(n4 & n1);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, sr_q, sum_q;
    logic             c_q, carry_q;
    logic [CntW-1:0]  cnt_q;
    logic             cell_sum, cell_carry;
    logic             last_bit;

    full_adder_nand u_cell (
        .a         (sa_q[0]),
        .b         (sb_q[0]),
        .carry_in  (c_q),
        .sum       (cell_sum),
        .carry_out (cell_carry)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            sa_q  <= a_in;
            sb_q  <= b_in;
            c_q   <= carry_in;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            sr_q  <= {cell_sum, sr_q[WIDTH-1:1]};
            c_q   <= cell_carry;
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            cnt_q <= cnt_q + CntW'(1);
            // Result registers update only on the final bit so they stay stable through RUN.
            if (last_bit) begin
                sum_q   <= {cell_sum, sr_q[WIDTH-1:1]};
                carry_q <= cell_carry;
            end
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=8 directed cases plus a WIDTH=3 sweep.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a_in      (a8),
        .b_in      (b8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum_out   (sum8),
        .carry_out (cout8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start3),
        .a_in      (a3),
        .b_in      (b3),
        .carry_in  (cin3),
        .busy      (busy3),
        .done      (done3),
        .sum_out   (sum3),
        .carry_out (cout3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string tag);
        int busy_n;
        int k;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy_n = 0;
        k = 0;
        while (!done8 && k < 20) begin
            if (busy8) busy_n++;
            @(negedge clk);
            k++;
        end
        check({tag, " done"}, done8, 1);
        check({tag, " sum"}, sum8, es);
        check({tag, " carry"}, cout8, ec);
        check({tag, " busy_cycles"}, busy_n, 8);
        check({tag, " busy_at_done"}, busy8, 0);
        @(negedge clk);
        check({tag, " done_drop"}, done8, 0);
    endtask

    initial begin
        int done_n;
        int k;
        int last_done;
        logic [3:0] exp3;
        logic [6:0] idx;

        #1;
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset sum", sum8, 0);
        check("reset carry", cout8, 0);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "5a+3c");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff+ff+1");

        // Second start during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        check("ignored sum_hold", sum8, 8'hFF);
        @(negedge clk);
        start8 = 1'b0;
        done_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (done8) begin
                done_n++;
                check("ignored sum", sum8, 8'h77);
            end
            @(negedge clk);
        end
        check("ignored done_count", done_n, 1);

        // Asynchronous reset in the middle of bit 4.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("abort busy_before", busy8, 1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy8, 0);
        check("abort done", done8, 0);
        check("abort sum", sum8, 0);
        check("abort carry", cout8, 0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_n++;
        end
        check("abort no_done", done_n, 0);
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "01+01");

        // WIDTH=3 sweep with start held high; operands advance during each done cycle.
        @(negedge clk);
        idx = '0;
        {cin3, a3, b3} = idx;
        start3 = 1'b1;
        last_done = 0;
        for (int i = 0; i < 128; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done3 && k < 10);
            check("w3 done", done3, 1);
            exp3 = {1'b0, a3} + {1'b0, b3} + {3'b0, cin3};
            check($sformatf("w3 sum %0d", i), {cout3, sum3}, exp3);
            if (i > 0) check("w3 spacing", cyc - last_done, 5);
            last_done = cyc;
            idx = 7'(i + 1);
            {cin3, a3, b3} = idx;
        end
        start3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
